kbd_event_arbiter: RTL



---
 rtl/kbd_pkg.sv | 56 +++++
 rtl/kbd_event_fifo.sv | 56 +++++
 rtl/kbd_event_arbiter.sv | 94 +++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared event layout, hotkey codes and focus encodings
package kbd_pkg;

  localparam int EV_W = 16;

  localparam int EV_BIT_ASCII = 15;
  localparam int EV_BIT_E0    = 14;
  localparam int EV_BIT_SHIFT = 13;
  localparam int EV_BIT_CTRL  = 12;
  localparam int EV_BIT_ALT   = 11;
  localparam int EV_CODE_MSB  = 7;
  localparam int EV_CODE_LSB  = 0;

  localparam logic [7:0] HOTKEY_F1 = 8'h05;
  localparam logic [7:0] HOTKEY_F2 = 8'h06;

  localparam logic FOCUS_TERM = 1'b0;
  localparam logic FOCUS_CPU  = 1'b1;

  typedef struct packed {
    logic       is_ascii;
    logic       is_e0;
    logic       shift;
    logic       ctrl;
    logic       alt;
    logic [2:0] rsvd;
    logic [7:0] code;
  } kbd_event_t;

  // ASCII wins over raw scan codes; an E0 code wins over the plain one.
  function automatic kbd_event_t pack_event(
    input logic       is_ascii,
    input logic [7:0] ascii,
    input logic [7:0] sc,
    input logic [7:0] sc_e0,
    input logic       shift,
    input logic       ctrl,
    input logic       alt
  );
    kbd_event_t ev;
    ev.is_ascii = is_ascii;
    ev.is_e0    = (sc_e0 != 8'h00);
    ev.shift    = shift;
    ev.ctrl     = ctrl;
    ev.alt      = alt;
    ev.rsvd     = 3'b000;
    if (is_ascii)
      ev.code = ascii;
    else if (sc_e0 != 8'h00)
      ev.code = sc_e0;
    else
      ev.code = sc;
    return ev;
  endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// rtl/kbd_event_fifo.sv - circular event buffer with push/pop/flush
module kbd_event_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!clrn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clk) begin
    if (clrn && !flush && do_push)
      mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/kbd_event_arbiter.sv
// rtl/kbd_event_arbiter.sv - keyboard event queue steered to terminal or CPU
module kbd_event_arbiter
  import kbd_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          newKey,
  input  logic [7:0]    scanCode,
  input  logic [7:0]    scanCode_E0,
  input  logic [7:0]    ASCII,
  input  logic          isASCIIkey,
  input  logic          shift,
  input  logic          ctrl,
  input  logic          alt,
  output logic [15:0]   ev_data,
  output logic          ev_valid0,
  input  logic          ev_ready0,
  output logic          ev_valid1,
  input  logic          ev_ready1,
  output logic          focus,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          clear_ovf
);

  kbd_event_t ev_word;
  logic       hot_f1;
  logic       hot_f2;
  logic       hotkey;
  logic       valid_focus;
  logic       ready_focus;
  logic       pop;
  logic       push;
  logic       drop;
  logic       fifo_full;
  logic       fifo_empty;

  assign ev_word = pack_event(isASCIIkey, ASCII, scanCode, scanCode_E0,
                              shift, ctrl, alt);

  assign hot_f1 = newKey && ctrl && alt && (scanCode == HOTKEY_F1);
  assign hot_f2 = newKey && ctrl && alt && (scanCode == HOTKEY_F2);
  assign hotkey = hot_f1 || hot_f2;

  // Only the focused consumer's ready can retire the head event.
  assign valid_focus = !fifo_empty;
  assign ready_focus = (focus == FOCUS_CPU) ? ev_ready1 : ev_ready0;
  assign pop         = valid_focus && ready_focus;

  assign push = newKey && !hotkey && (!fifo_full || pop);
  assign drop = newKey && !hotkey && fifo_full && !pop;

  kbd_event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EV_W)
  ) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (push),
    .pop   (pop),
    .flush (hotkey),
    .wdata (ev_word),
    .rdata (ev_data),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!clrn)
      focus <= FOCUS_TERM;
    else if (hot_f1)
      focus <= FOCUS_TERM;
    else if (hot_f2)
      focus <= FOCUS_CPU;
  end

  // A drop in the same cycle as clear_ovf must leave the flag set.
  always_ff @(posedge clk) begin
    if (!clrn)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
    else if (clear_ovf)
      overflow <= 1'b0;
  end

  assign ev_valid0 = valid_focus && (focus == FOCUS_TERM);
  assign ev_valid1 = valid_focus && (focus == FOCUS_CPU);

endmodule
